// File: rtl/aud_btm_fifo.sv
// AUD branch-trace receiver: decodes the nibble stream into branch-destination
// records, reconstructs compressed addresses, timestamps and queues them in a FWFT FIFO.
module aud_btm_fifo #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic              aud_ck,
  input  logic              rst,
  input  logic [3:0]        aud_data,
  input  logic              aud_nsync,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [3:0]        rec_nib,
  output logic              rec_complete,
  output logic              rec_overrun,
  output logic [TS_W-1:0]   rec_ts,
  output logic              bus_err,
  output logic              ovf,
  output logic [7:0]        ovf_cnt,
  input  logic              ovf_clr
);

  localparam int MAX_NIB = ADDR_W / 4;
  localparam logic [3:0] MAX_NIB4 = 4'(MAX_NIB);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        nib;
    logic              complete;
    logic              overrun;
    logic [TS_W-1:0]   ts;
  } rec_t;

  logic [TS_W-1:0]   ts;
  logic [3:0]        nib_cnt;
  logic [3:0]        expected;
  logic [ADDR_W-1:0] shadow;
  logic              overrun_q;
  logic [TS_W-1:0]   first_ts;
  logic [ADDR_W-1:0] last_good;

  rec_t              mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       fill;
  rec_t              head;

  logic              close;
  logic              is_complete;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] recon;
  logic [3:0]        start_len;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // Nibbles received so far replace the low bits; the rest come from the last good address.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_NIB; i++)
      if (4'(i) < nib_cnt) mask[4*i +: 4] = 4'hF;
    recon       = (shadow & mask) | (last_good & ~mask);
    is_complete = (nib_cnt == expected);
    close       = aud_nsync && (nib_cnt != 4'd0);
    start_len   = 4'd1 << aud_data[1:0];
    if (start_len > MAX_NIB4) start_len = MAX_NIB4;
  end

  assign full    = (fill == (PW+1)'(DEPTH));
  assign pop     = rec_valid && rec_ready;
  assign push_ok = close && (!full || pop);
  assign drop    = close && full && !pop;

  always_ff @(posedge aud_ck or posedge rst) begin
    if (rst) begin
      ts        <= '0;
      nib_cnt   <= '0;
      expected  <= MAX_NIB4;
      shadow    <= '0;
      overrun_q <= 1'b0;
      first_ts  <= '0;
      last_good <= '0;
      bus_err   <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (aud_nsync) begin
        if (aud_data == 4'b0011) begin
          bus_err <= 1'b0;
        end else if (aud_data[3:2] == 2'b10) begin
          bus_err  <= 1'b0;
          expected <= start_len;
        end else begin
          bus_err <= 1'b1;
        end
        if (close) begin
          nib_cnt   <= '0;
          overrun_q <= 1'b0;
          if (is_complete) last_good <= recon;
        end
      end else begin
        if (nib_cnt == 4'd0) first_ts <= ts;
        if (nib_cnt < MAX_NIB4) begin
          for (int i = 0; i < MAX_NIB; i++)
            if (nib_cnt == 4'(i)) shadow[4*i +: 4] <= aud_data;
          nib_cnt <= nib_cnt + 4'd1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  // Storage is not reset; outputs are masked whenever the FIFO is empty.
  always_ff @(posedge aud_ck) begin
    if (push_ok)
      mem[wr_ptr] <= '{addr: recon, nib: nib_cnt, complete: is_complete,
                       overrun: overrun_q, ts: first_ts};
  end

  always_ff @(posedge aud_ck or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      ovf     <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fill <= fill + 1'b1;
      else if (pop && !push_ok) fill <= fill - 1'b1;
      if (ovf_clr) begin
        ovf     <= 1'b0;
        ovf_cnt <= '0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end

  assign head         = mem[rd_ptr];
  assign rec_valid    = (fill != '0);
  assign rec_addr     = rec_valid ? head.addr     : '0;
  assign rec_nib      = rec_valid ? head.nib      : '0;
  assign rec_complete = rec_valid ? head.complete : 1'b0;
  assign rec_overrun  = rec_valid ? head.overrun  : 1'b0;
  assign rec_ts       = rec_valid ? head.ts       : '0;

endmodule

// File: tb/tb_aud_btm_fifo.sv
// Directed bench for aud_btm_fifo: a 32-bit/DEPTH=4 instance for decode, FIFO and
// reset checks, and a 16-bit instance for the overrun/length-cap case.
module tb_aud_btm_fifo;

  logic        aud_ck = 1'b0;
  logic        rst;
  always #5 aud_ck = ~aud_ck;

  logic [3:0]  aud_data;
  logic        aud_nsync, rec_ready, ovf_clr;
  logic        rec_valid, rec_complete, rec_overrun, bus_err, ovf;
  logic [31:0] rec_addr;
  logic [3:0]  rec_nib;
  logic [15:0] rec_ts;
  logic [7:0]  ovf_cnt;

  logic [3:0]  b_data;
  logic        b_nsync, b_ready, b_clr;
  logic        b_valid, b_complete, b_overrun, b_err, b_ovf;
  logic [15:0] b_addr;
  logic [3:0]  b_nib;
  logic [15:0] b_ts;
  logic [7:0]  b_cnt;

  aud_btm_fifo #(.ADDR_W(32), .DEPTH(4), .TS_W(16)) dut (
    .aud_ck(aud_ck), .rst(rst), .aud_data(aud_data), .aud_nsync(aud_nsync),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr),
    .rec_nib(rec_nib), .rec_complete(rec_complete), .rec_overrun(rec_overrun),
    .rec_ts(rec_ts), .bus_err(bus_err), .ovf(ovf), .ovf_cnt(ovf_cnt),
    .ovf_clr(ovf_clr));

  aud_btm_fifo #(.ADDR_W(16), .DEPTH(4), .TS_W(16)) dut16 (
    .aud_ck(aud_ck), .rst(rst), .aud_data(b_data), .aud_nsync(b_nsync),
    .rec_valid(b_valid), .rec_ready(b_ready), .rec_addr(b_addr),
    .rec_nib(b_nib), .rec_complete(b_complete), .rec_overrun(b_overrun),
    .rec_ts(b_ts), .bus_err(b_err), .ovf(b_ovf), .ovf_cnt(b_cnt),
    .ovf_clr(b_clr));

  // Reference cycle count since reset release, used for expected timestamps.
  logic [15:0] tb_ts;
  always @(posedge aud_ck or posedge rst)
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 16'd1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        nsync;
    logic [3:0]  data;
    logic        ready;
    logic        chk;
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  nib;
    logic        cmp;
    logic        ovr;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic [3:0] d, input logic rdy, input logic c,
                     input logic v, input logic [31:0] a, input logic [3:0] n,
                     input logic cp, input logic ov, input logic e);
    vq.push_back('{s, d, rdy, c, v, a, n, cp, ov, e});
  endtask

  task automatic send(input logic s, input logic [3:0] d);
    @(negedge aud_ck);
    aud_nsync = s;
    aud_data  = d;
  endtask

  task automatic send16(input logic s, input logic [3:0] d);
    @(negedge aud_ck);
    b_nsync = s;
    b_data  = d;
  endtask

  // Two-nibble packet (n0, 0) after a length-2 start symbol; returns its timestamp.
  task automatic push_rec(input logic [3:0] n0, output logic [15:0] t);
    send(1'b1, 4'h9);
    send(1'b0, n0);
    t = tb_ts;
    send(1'b0, 4'h0);
    send(1'b1, 4'h3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   32'(rec_valid),    32'd0);
    check({tag, "_addr"},    rec_addr,          32'd0);
    check({tag, "_nib"},     32'(rec_nib),      32'd0);
    check({tag, "_cmp"},     32'(rec_complete), 32'd0);
    check({tag, "_ovr"},     32'(rec_overrun),  32'd0);
    check({tag, "_ts"},      32'(rec_ts),       32'd0);
    check({tag, "_err"},     32'(bus_err),      32'd0);
    check({tag, "_ovf"},     32'(ovf),          32'd0);
    check({tag, "_ovf_cnt"}, 32'(ovf_cnt),      32'd0);
  endtask

  logic [15:0] tsx [6];
  logic [15:0] tdummy;

  initial begin
    rst = 1'b1;
    aud_nsync = 1'b1; aud_data = 4'h3; rec_ready = 1'b0; ovf_clr = 1'b0;
    b_nsync = 1'b1;   b_data = 4'h3;   b_ready = 1'b0;   b_clr = 1'b0;

    // Decode vectors for the 32-bit instance, all comparisons #1 after the edge.
    add(1, 4'hB, 0, 1, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h4, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h3, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h2, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h8, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h7, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h6, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h5, 0, 1, 0, 32'h0, 0, 0, 0, 0);
    add(1, 4'h3, 0, 1, 1, 32'h56781234, 8, 1, 0, 0);
    add(1, 4'h3, 1, 1, 0, 32'h0, 0, 0, 0, 0);
    add(1, 4'h9, 0, 1, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'hA, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'hB, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(1, 4'h3, 0, 1, 1, 32'h567812BA, 2, 1, 0, 0);
    add(1, 4'h3, 1, 1, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(1, 4'h3, 0, 1, 1, 32'h567812BF, 1, 0, 0, 0);
    add(1, 4'h3, 1, 1, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h2, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h3, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(1, 4'h3, 0, 1, 1, 32'h56781321, 3, 0, 0, 0);
    add(1, 4'h3, 1, 1, 0, 32'h0, 0, 0, 0, 0);
    add(0, 4'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(1, 4'h3, 0, 1, 1, 32'h567812B0, 1, 0, 0, 0);
    add(1, 4'h3, 1, 1, 0, 32'h0, 0, 0, 0, 0);
    add(1, 4'h6, 0, 1, 0, 32'h0, 0, 0, 0, 1);
    add(1, 4'h3, 0, 1, 0, 32'h0, 0, 0, 0, 0);

    #12;
    check_all_zero("reset");
    @(negedge aud_ck);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge aud_ck);
      aud_nsync = vq[i].nsync;
      aud_data  = vq[i].data;
      rec_ready = vq[i].ready;
      @(posedge aud_ck);
      #1;
      if (vq[i].chk) begin
        check($sformatf("v%0d_valid", i), 32'(rec_valid),    32'(vq[i].valid));
        check($sformatf("v%0d_addr", i),  rec_addr,          vq[i].addr);
        check($sformatf("v%0d_nib", i),   32'(rec_nib),      32'(vq[i].nib));
        check($sformatf("v%0d_cmp", i),   32'(rec_complete), 32'(vq[i].cmp));
        check($sformatf("v%0d_ovr", i),   32'(rec_overrun),  32'(vq[i].ovr));
        check($sformatf("v%0d_err", i),   32'(bus_err),      32'(vq[i].err));
      end
    end
    rec_ready = 1'b0;

    // Six complete records into a 4-deep FIFO with no consumer: two drops.
    for (int k = 0; k < 6; k++) push_rec(4'(k + 1), tsx[k]);
    @(posedge aud_ck);
    #1;
    check("full_ovf",     32'(ovf),       32'd1);
    check("full_ovf_cnt", 32'(ovf_cnt),   32'd2);
    check("full_valid",   32'(rec_valid), 32'd1);
    check("full_head",    rec_addr,       32'h56781201);

    @(negedge aud_ck);
    ovf_clr = 1'b1;
    @(posedge aud_ck);
    #1;
    ovf_clr = 1'b0;
    check("clr_ovf",     32'(ovf),     32'd0);
    check("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);

    for (int k = 0; k < 4; k++) begin
      @(negedge aud_ck);
      check($sformatf("drain%0d_valid", k), 32'(rec_valid), 32'd1);
      check($sformatf("drain%0d_addr", k),  rec_addr,       32'h56781200 + 32'(k + 1));
      check($sformatf("drain%0d_ts", k),    32'(rec_ts),    32'(tsx[k]));
      check($sformatf("drain%0d_cmp", k),   32'(rec_complete), 32'd1);
      rec_ready = 1'b1;
      @(posedge aud_ck);
      #1;
      rec_ready = 1'b0;
    end
    check("drain_empty", 32'(rec_valid), 32'd0);

    // 16-bit instance: length capped at 4 nibbles, two extra nibbles flag overrun.
    send16(1'b1, 4'hB);
    for (int k = 1; k <= 6; k++) send16(1'b0, 4'(k));
    send16(1'b1, 4'h3);
    @(posedge aud_ck);
    #1;
    check("a16_valid", 32'(b_valid),    32'd1);
    check("a16_addr",  32'(b_addr),     32'h4321);
    check("a16_nib",   32'(b_nib),      32'd4);
    check("a16_ovr",   32'(b_overrun),  32'd1);
    check("a16_cmp",   32'(b_complete), 32'd1);

    // Reset mid-packet with a record still queued.
    push_rec(4'h7, tdummy);
    @(posedge aud_ck);
    #1;
    check("pre_rst_valid", 32'(rec_valid), 32'd1);
    send(1'b1, 4'hB);
    send(1'b0, 4'h1);
    send(1'b0, 4'h2);
    send(1'b0, 4'h3);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge aud_ck);
    rst = 1'b0;
    aud_nsync = 1'b1;
    aud_data  = 4'h3;
    send(1'b1, 4'h9);
    send(1'b0, 4'h5);
    send(1'b0, 4'h6);
    send(1'b1, 4'h3);
    @(posedge aud_ck);
    #1;
    check("post_rst_valid", 32'(rec_valid),    32'd1);
    check("post_rst_addr",  rec_addr,          32'h00000065);
    check("post_rst_nib",   32'(rec_nib),      32'd2);
    check("post_rst_cmp",   32'(rec_complete), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aud_btm_fifo.md
Name: aud_btm_fifo

Overview:
- Next-generation AUD branch-trace receiver.
- Decodes the 4-bit AUD nibble stream into branch-destination records and reconstructs compressed addresses against the last complete address.
- Timestamps each record and queues it in a parametrised FIFO with a valid/ready drain port towards the host/USB side.
- Improves on the current receiver: configurable address width, buffering, overflow accounting and per-record status instead of a single overwritten address register.

Parameters:
ADDR_W, 32, reconstructed address width; multiple of 4, range 8..32; MAX_NIB = ADDR_W/4
DEPTH, 16, FIFO entries; power of 2, range 2..256
TS_W, 16, timestamp counter width

Ports:
aud_ck  in  1  AUD clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
aud_data  in  4  AUD data nibble
aud_nsync  in  1  1 = sync/command cycle, 0 = address nibble cycle
rec_valid  out  1  FIFO head record available
rec_ready  in  1  consumer accepts head record
rec_addr  out  ADDR_W  reconstructed address
rec_nib  out  4  nibbles received for this record (0..MAX_NIB)
rec_complete  out  1  nibble count matched the announced length
rec_overrun  out  1  more than MAX_NIB nibbles were seen
rec_ts  out  TS_W  timestamp of the record's first nibble
bus_err  out  1  last sync cycle carried an invalid symbol
ovf  out  1  sticky: a record was dropped because the FIFO was full
ovf_cnt  out  8  dropped-record count, saturates at 255
ovf_clr  in  1  synchronous clear of ovf and ovf_cnt

Behaviour:
- Reset (asynchronous): all outputs and internal state 0; FIFO empty; last_good = 0; expected length = MAX_NIB; ts = 0.
- ts: free-running TS_W counter, +1 every cycle, wraps.
- Sync cycle (aud_nsync = 1):
  - 4'b0011: idle symbol; bus_err <= 0.
  - 4'b10mm: start symbol; bus_err <= 0; expected <= min(1<<mm, MAX_NIB).
  - Any other value: bus_err <= 1; expected unchanged.
  - If the nibble count is nonzero, the packet is closed: push one record and reset the count to 0.
  - Record close and symbol decode happen in the same cycle.
- Nibble cycle (aud_nsync = 0):
  - Nibble k (0-based, k < MAX_NIB) is written to shadow address bits [4k+3:4k].
  - Count increments, saturating at MAX_NIB.
  - A nibble at k >= MAX_NIB is discarded and sets the overrun flag.
  - k = 0 captures the current ts value.
- Address reconstruction at close: bits below 4*count come from the received nibbles; the remaining upper bits come from last_good.
- rec_complete = (count == expected).
  - Complete: last_good <= reconstructed address.
  - Incomplete: last_good is unchanged and the record is still pushed, with rec_complete = 0.
- Nibbles arriving without a preceding start symbol use the current expected value; no special case.
- FIFO:
  - First-word fall-through; a record is visible on rec_* one cycle after its closing sync edge.
  - Pop when rec_valid & rec_ready.
  - rec_* are held stable while rec_valid = 1 and not popped.
- Full handling:
  - Push while full with no pop: the record is dropped; ovf <= 1; ovf_cnt +1, saturating.
  - Push while full with a simultaneous pop: both happen; no drop.
  - Push and pop when empty: the record appears next cycle; no bypass.
- ovf_clr has priority over a same-cycle increment; the result is 0.
- Reset mid-packet discards the partial packet and FIFO contents; no record is emitted.

Test Plan:
- ADDR_W=32: sync 4'b1011, nibbles 4,3,2,1,8,7,6,5, sync 4'b0011 -> one record: rec_addr=32'h56781234, rec_nib=8, rec_complete=1, bus_err=0.
- After the above: sync 4'b1001 (expected 2), nibbles A,B, sync -> rec_addr=32'h567812BA, complete=1. Then nibble F, sync -> rec_addr=32'h567812BF, rec_nib=1, complete=0; last_good stays 32'h567812BA.
- Sync 4'b0110 -> bus_err=1 the next cycle; a following 4'b0011 -> bus_err=0; no record pushed by either.
- DEPTH=4, rec_ready=0, push 6 complete records -> FIFO holds the first 4; ovf=1, ovf_cnt=2. Pulse ovf_clr -> both 0. Drain -> addresses in order with increasing rec_ts.
- ADDR_W=16: start 4'b1011, 6 nibbles, sync -> rec_nib=4, rec_overrun=1, complete=1 (expected capped at 4).
- Assert rst during nibble 3 of a packet -> rec_valid=0 and all outputs 0 immediately. After release, a fresh packet decodes with last_good=0.
